sierpinski_lfsr: RTL and testbench

Free-running 16-bit rule-90 (Pascal's triangle mod 2) row generator. Each clock it produces the next row of a Sierpinski triangle and exposes the middle 14 cells as `lfsr_out`. It is the core of the `tt_um_sierpinski_lfsr` tile, and it drives a display or capture path that renders one row per clock. The block is purely autonomous: it has no data inputs, only a clock and a reset.

---
 rtl/sierpinski_pkg.sv | 16 +
 rtl/sierpinski_lfsr_rule90_step.sv | 28 ++
 rtl/sierpinski_lfsr.sv | 77 +++++++
 tb/tb_sierpinski_lfsr.sv | 134 +++++++++++++
 4 files changed

// File: rtl/sierpinski_pkg.sv
// Shared types, widths and the rule-90 update for the Sierpinski row generator.
package sierpinski_pkg;

    localparam int ROW_W = 16;
    localparam int VIS_W = 14;

    typedef logic [ROW_W-1:0] row_t;

    localparam row_t DEFAULT_SEED = 16'h0080;

    // Each cell becomes the XOR of its two neighbours; cells beyond the edges read as zero.
    function automatic row_t rule90_next(input row_t cur);
        return {cur[ROW_W-2:0], 1'b0} ^ {1'b0, cur[ROW_W-1:1]};
    endfunction

endpackage

// File: rtl/sierpinski_lfsr_rule90_step.sv
// Combinational next-row function with a zero guard that falls back to the seed.
module sierpinski_lfsr_rule90_step
    import sierpinski_pkg::*;
#(
    parameter row_t SEED = DEFAULT_SEED
) (
    input  row_t cur_row,
    output row_t next_row,
    output logic zero_hit
);

    row_t raw_next_s;

    // Apply rule 90; an all-zero result would freeze the generator, so reload the seed.
    always_comb begin
        raw_next_s = rule90_next(cur_row);
        zero_hit   = 1'b0;
        next_row   = raw_next_s;
        if (raw_next_s == 16'h0000) begin
            zero_hit = 1'b1;
            next_row = SEED;
        end else begin
            zero_hit = 1'b0;
            next_row = raw_next_s;
        end
    end

endmodule

// File: rtl/sierpinski_lfsr.sv
// Free-running rule-90 Sierpinski row generator; one new row per clock, middle 14 cells visible.
module sierpinski_lfsr
    import sierpinski_pkg::*;
#(
    parameter row_t SEED        = DEFAULT_SEED,
    parameter int   RESEED_ROWS = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [VIS_W-1:0] lfsr_out
);

    localparam int GEN_W = (RESEED_ROWS > 0) ? $clog2(RESEED_ROWS + 1) : 1;
    localparam logic [GEN_W-1:0] GEN_LAST = (RESEED_ROWS > 0) ? GEN_W'(RESEED_ROWS - 1) : '0;

    // An all-zero seed can never produce a visible pattern.
    if (SEED == 16'h0000) begin : g_seed_check
        $error("sierpinski_lfsr: SEED must be nonzero");
    end

    row_t             row_r;
    row_t             row_nxt_s;
    row_t             step_row_s;
    logic             zero_hit_s;
    logic             reseed_s;
    logic [GEN_W-1:0] gen_r;
    logic [GEN_W-1:0] gen_nxt_s;

    sierpinski_lfsr_rule90_step #(
        .SEED(SEED)
    ) u_step (
        .cur_row (row_r),
        .next_row(step_row_s),
        .zero_hit(zero_hit_s)
    );

    // Choose between the rule-90 step and a seed reload; any reload restarts the generation count.
    always_comb begin
        reseed_s  = 1'b0;
        row_nxt_s = step_row_s;
        gen_nxt_s = gen_r;
        if (RESEED_ROWS != 0) begin
            if (gen_r == GEN_LAST) begin
                reseed_s = 1'b1;
            end else begin
                reseed_s = 1'b0;
            end
        end else begin
            reseed_s = 1'b0;
        end

        if (reseed_s || zero_hit_s) begin
            row_nxt_s = SEED;
            gen_nxt_s = '0;
        end else if (RESEED_ROWS != 0) begin
            row_nxt_s = step_row_s;
            gen_nxt_s = gen_r + GEN_W'(1);
        end else begin
            row_nxt_s = step_row_s;
            gen_nxt_s = '0;
        end
    end

    // Row and generation state; reset (active high on rst_n) forces the seed immediately.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            row_r <= SEED;
            gen_r <= '0;
        end else begin
            row_r <= row_nxt_s;
            gen_r <= gen_nxt_s;
        end
    end

    assign lfsr_out = row_r[VIS_W:1];

endmodule

// File: tb/tb_sierpinski_lfsr.sv
// Directed bench for sierpinski_lfsr: reset, known rows, software rule-90 model, reseed and period.
module tb_sierpinski_lfsr;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [13:0] out_a;
    logic [13:0] out_b;

    int err_cnt = 0;
    int chk_cnt = 0;

    always #5 clk = ~clk;

    sierpinski_lfsr u_dut (
        .clk     (clk),
        .rst_n   (rst),
        .lfsr_out(out_a)
    );

    sierpinski_lfsr #(
        .RESEED_ROWS(4)
    ) u_dut_rs (
        .clk     (clk),
        .rst_n   (rst),
        .lfsr_out(out_b)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Independent per-cell rule-90 reference with zero boundaries.
    function automatic logic [15:0] model_next(input logic [15:0] r);
        logic [15:0] n;
        logic        lft;
        logic        rgt;
        for (int i = 0; i < 16; i++) begin
            lft  = (i < 15) ? r[i+1] : 1'b0;
            rgt  = (i > 0) ? r[i-1] : 1'b0;
            n[i] = lft ^ rgt;
        end
        return n;
    endfunction

    logic [13:0] known_tab [8];
    logic [13:0] rs_tab    [4];
    logic [15:0] mrow;
    int          period_ref;
    int          period_dut;
    logic [31:0] zero_seen;

    initial begin
        known_tab = '{14'h00A0, 14'h0110, 14'h02A8, 14'h0404,
                      14'h0A0A, 14'h1111, 14'h2AAA, 14'h0000};
        rs_tab    = '{14'h0040, 14'h00A0, 14'h0110, 14'h02A8};

        // asynchronous reset mid-clock, then hold for 3 clocks
        #12 rst = 1'b1;
        #1;
        check_val("rst_async_out", {18'd0, out_a}, 32'h0040);
        check_val("rst_async_rs", {18'd0, out_b}, 32'h0040);
        for (int k = 0; k < 3; k++) begin
            step();
            check_val("rst_hold_out", {18'd0, out_a}, 32'h0040);
            check_val("rst_hold_row", {16'd0, u_dut.row_r}, 32'h0080);
        end

        // release and run 20 clocks against the model, known table and reseed table
        rst  = 1'b0;
        mrow = 16'h0080;
        for (int k = 1; k <= 20; k++) begin
            step();
            mrow = model_next(mrow);
            check_val("model_row", {16'd0, u_dut.row_r}, {16'd0, mrow});
            check_val("model_out", {18'd0, out_a}, {18'd0, mrow[14:1]});
            if (k <= 8) begin
                check_val("known_out", {18'd0, out_a}, {18'd0, known_tab[k-1]});
            end
            check_val("reseed4_out", {18'd0, out_b}, {18'd0, rs_tab[k % 4]});
        end

        // reset mid-sequence, then restart
        repeat (5) step();
        #2 rst = 1'b1;
        #1;
        check_val("mid_rst_out", {18'd0, out_a}, 32'h0040);
        @(negedge clk);
        rst = 1'b0;
        check_val("restart_row0", {18'd0, out_a}, 32'h0040);
        step();
        check_val("restart_row1", {18'd0, out_a}, 32'h00A0);
        check_val("restart_rs_row1", {18'd0, out_b}, 32'h00A0);

        // long run: row never zero, period matches reference
        rst = 1'b1;
        #1;
        @(negedge clk);
        rst = 1'b0;
        mrow       = 16'h0080;
        period_ref = 0;
        for (int i = 1; i <= 10000; i++) begin
            mrow = model_next(mrow);
            if (mrow == 16'h0080 && period_ref == 0) begin
                period_ref = i;
            end
        end
        period_dut = 0;
        zero_seen  = 32'd0;
        for (int i = 1; i <= 10000; i++) begin
            step();
            if (u_dut.row_r == 16'h0000) begin
                zero_seen = 32'd1;
            end
            if (period_dut == 0 && u_dut.row_r == 16'h0080) begin
                period_dut = i;
            end
        end
        check_val("never_zero", zero_seen, 32'd0);
        check_val("period", period_dut, period_ref);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
